// File: rtl/isa_camac_bridge.sv
// ISA I/O window to CAMAC bridge: byte-lane shadow word, CAMAC read/write cycles with ack/timeout.
// Optional LAM interrupt path is built when ISA_CAMAC_BRIDGE_IRQ_EN is defined.
module isa_camac_bridge #(
    parameter logic [9:0] BASE_ADDR      = 10'h100,
    parameter int         CB_WIDTH       = 16,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                isa_clk,
    input  logic                isa_reset,
    input  logic [9:0]          isa_addr,
    input  logic                isa_aen,
    input  logic                isa_ior,
    input  logic                isa_iow,
    input  logic [7:0]          isa_data_in,
    output logic [7:0]          isa_data_out,
    output logic                isa_data_oe,
    output logic                isa_chrdy,
    output logic [3:0]          cb_subaddr,
    output logic [CB_WIDTH-1:0] cb_data_out,
    input  logic [CB_WIDTH-1:0] cb_data_in,
    output logic                cb_req,
    output logic                cb_write,
    input  logic                cb_ack,
`ifdef ISA_CAMAC_BRIDGE_IRQ_EN
    input  logic                cb_lam,
    output logic                isa_irq,
`endif
    input  logic                cb_q
);

    localparam int              B        = CB_WIDTH / 8;
    localparam int              OW       = $clog2(B + 1);
    localparam logic [10:0]     ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [10:0]     ADDR_HI  = ADDR_LO + 11'(B);
    localparam logic [OW-1:0]   OFF_CTRL = OW'(B);
    localparam logic [OW-1:0]   OFF_LAST = OW'(B - 1);
    localparam logic [7:0]      TO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [CB_WIDTH-1:0]   shadow_q, shadow_d, shadow_wr;
    logic [7:0]            data_out_q, data_out_d;
    logic                  cb_write_q, cb_write_d;
    logic [CB_WIDTH-1:0]   cb_dout_q, cb_dout_d;
    logic [3:0]            subaddr_q, subaddr_d;
    logic                  irq_en_q, irq_en_d;
    logic                  qflag_q, qflag_d;
    logic                  toflag_q, toflag_d;
    logic                  cb_req_q, chrdy_q;

    logic [1:0]            ior_sync_q, iow_sync_q;
    logic                  ior_prev_q, iow_prev_q;
    logic                  ior_s, iow_s, rd_edge, wr_edge;
    logic                  hit, lam_s;
    logic [OW-1:0]         off, lane;
    logic [7:0]            lane_byte, status;

    // Address is stable for the whole strobe, so it is decoded directly.
    assign hit = !isa_aen && ({1'b0, isa_addr} >= ADDR_LO) && ({1'b0, isa_addr} <= ADDR_HI);
    assign off = OW'(isa_addr - BASE_ADDR);
    assign lane = (off < OFF_CTRL) ? off : '0;
    assign lane_byte = shadow_q[8*lane +: 8];

    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            ior_sync_q <= 2'b11;
            iow_sync_q <= 2'b11;
            ior_prev_q <= 1'b1;
            iow_prev_q <= 1'b1;
        end else begin
            ior_sync_q <= {ior_sync_q[0], isa_ior};
            iow_sync_q <= {iow_sync_q[0], isa_iow};
            ior_prev_q <= ior_sync_q[1];
            iow_prev_q <= iow_sync_q[1];
        end
    end

    assign ior_s = ior_sync_q[1];
    assign iow_s = iow_sync_q[1];
    // A falling strobe only counts while the other strobe is idle high.
    assign rd_edge = ior_prev_q && !ior_s && iow_s;
    assign wr_edge = iow_prev_q && !iow_s && ior_s;

`ifdef ISA_CAMAC_BRIDGE_IRQ_EN
    logic [1:0] lam_sync_q;
    logic       irq_q;

    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            lam_sync_q <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            lam_sync_q <= {lam_sync_q[0], cb_lam};
            irq_q      <= lam_sync_q[1] & irq_en_q;
        end
    end

    assign lam_s   = lam_sync_q[1];
    assign isa_irq = irq_q;
`else
    logic unused_irq_en;
    assign lam_s         = 1'b0;
    assign unused_irq_en = irq_en_q;
`endif

    assign status = {4'b0000, lam_s, toflag_q, qflag_q, state_q != S_IDLE};

    always_comb begin
        shadow_wr = shadow_q;
        shadow_wr[8*lane +: 8] = isa_data_in;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        data_out_d = data_out_q;
        cb_write_d = cb_write_q;
        cb_dout_d  = cb_dout_q;
        subaddr_d  = subaddr_q;
        irq_en_d   = irq_en_q;
        qflag_d    = qflag_q;
        toflag_d   = toflag_q;
        case (state_q)
            S_IDLE: begin
                if (hit && wr_edge) begin
                    if (off == OFF_CTRL) begin
                        subaddr_d = isa_data_in[3:0];
                        irq_en_d  = isa_data_in[7];
                    end else begin
                        shadow_d = shadow_wr;
                        if (off == OFF_LAST) begin
                            state_d    = S_WAIT;
                            cnt_d      = 8'd0;
                            cb_write_d = 1'b1;
                            cb_dout_d  = shadow_wr;
                        end
                    end
                end else if (hit && rd_edge) begin
                    if (off == OFF_CTRL) begin
                        data_out_d = status;
                    end else if (off == '0) begin
                        state_d    = S_WAIT;
                        cnt_d      = 8'd0;
                        cb_write_d = 1'b0;
                    end else begin
                        data_out_d = lane_byte;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cb_ack) begin
                    qflag_d  = cb_q;
                    toflag_d = 1'b0;
                    state_d  = S_HOLD;
                    if (!cb_write_q) begin
                        shadow_d   = cb_data_in;
                        data_out_d = cb_data_in[7:0];
                    end
                end else if (cnt_d == TO_LIMIT) begin
                    qflag_d  = 1'b0;
                    toflag_d = 1'b1;
                    state_d  = S_HOLD;
                    if (!cb_write_q) begin
                        shadow_d   = '1;
                        data_out_d = 8'hFF;
                    end
                end
            end
            S_HOLD: begin
                if (ior_s && iow_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request/ready are registered from the next state so they never glitch.
    always_ff @(posedge isa_clk or posedge isa_reset) begin
        if (isa_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            shadow_q   <= '0;
            data_out_q <= 8'h00;
            cb_write_q <= 1'b0;
            cb_dout_q  <= '0;
            subaddr_q  <= 4'h0;
            irq_en_q   <= 1'b0;
            qflag_q    <= 1'b0;
            toflag_q   <= 1'b0;
            cb_req_q   <= 1'b0;
            chrdy_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            cb_write_q <= cb_write_d;
            cb_dout_q  <= cb_dout_d;
            subaddr_q  <= subaddr_d;
            irq_en_q   <= irq_en_d;
            qflag_q    <= qflag_d;
            toflag_q   <= toflag_d;
            cb_req_q   <= (state_d == S_WAIT);
            chrdy_q    <= (state_d != S_WAIT);
        end
    end

    assign isa_data_out = data_out_q;
    assign isa_data_oe  = !ior_s && hit;
    assign isa_chrdy    = chrdy_q;
    assign cb_req       = cb_req_q;
    assign cb_write     = cb_write_q;
    assign cb_data_out  = cb_dout_q;
    assign cb_subaddr   = subaddr_q;

endmodule

// File: tb/tb_isa_camac_bridge.sv
// Directed + randomized bench for isa_camac_bridge against a byte-level behavioural model.
module tb_isa_camac_bridge;
    localparam int          CBW  = 16;
    localparam int          B    = CBW / 8;
    localparam int          TO   = 8;
    localparam logic [9:0]  BASE = 10'h100;

    logic            isa_clk = 1'b0;
    logic            isa_reset;
    logic [9:0]      isa_addr;
    logic            isa_aen, isa_ior, isa_iow;
    logic [7:0]      isa_data_in, isa_data_out;
    logic            isa_data_oe, isa_chrdy;
    logic [3:0]      cb_subaddr;
    logic [CBW-1:0]  cb_data_out, cb_data_in;
    logic            cb_req, cb_write, cb_ack, cb_q;
`ifdef ISA_CAMAC_BRIDGE_IRQ_EN
    logic            cb_lam, isa_irq;
`endif

    isa_camac_bridge #(.BASE_ADDR(BASE), .CB_WIDTH(CBW), .TIMEOUT_CYCLES(TO)) dut (
        .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_addr(isa_addr), .isa_aen(isa_aen),
        .isa_ior(isa_ior), .isa_iow(isa_iow), .isa_data_in(isa_data_in),
        .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe), .isa_chrdy(isa_chrdy),
        .cb_subaddr(cb_subaddr), .cb_data_out(cb_data_out), .cb_data_in(cb_data_in),
        .cb_req(cb_req), .cb_write(cb_write), .cb_ack(cb_ack),
`ifdef ISA_CAMAC_BRIDGE_IRQ_EN
        .cb_lam(cb_lam), .isa_irq(isa_irq),
`endif
        .cb_q(cb_q));

    always #5 isa_clk = ~isa_clk;

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CAMAC crate responder: answers each request after ack_dly cycles.
    bit             ack_en = 0;
    int             ack_dly = 0;
    logic           seen_write;
    logic [CBW-1:0] seen_dout;
    initial begin
        cb_ack = 1'b0;
        forever begin
            @(negedge isa_clk);
            if (ack_en && cb_req === 1'b1) begin
                seen_write = cb_write;
                seen_dout  = cb_data_out;
                repeat (ack_dly) @(negedge isa_clk);
                cb_ack = 1'b1;
                @(negedge isa_clk);
                cb_ack = 1'b0;
            end
        end
    end

    int req_cur = 0, req_w = 0, req_pulses = 0;
    initial forever begin
        @(negedge isa_clk);
        if (cb_req === 1'b1) begin
            if (req_cur == 0) req_pulses++;
            req_cur++;
        end else if (req_cur > 0) begin
            req_w   = req_cur;
            req_cur = 0;
        end
    end

    // Behavioural model state
    logic [7:0] sh [B];
    logic       m_q, m_to, m_lam;
    logic [3:0] m_sub;

    task automatic model_reset();
        for (int i = 0; i < B; i++) sh[i] = 8'h00;
        m_q = 0; m_to = 0; m_sub = 4'h0;
    endtask

    task automatic isa_acc(input bit wr, input logic [9:0] a, input logic aen, input logic [7:0] d,
                           output logic [7:0] rd, output logic oe, output bit waited);
        int n;
        isa_addr = a; isa_aen = aen; isa_data_in = d; waited = 0;
        @(negedge isa_clk);
        if (wr) isa_iow = 1'b0; else isa_ior = 1'b0;
        repeat (4) begin
            @(negedge isa_clk);
            if (isa_chrdy === 1'b0) waited = 1;
        end
        n = 0;
        while (isa_chrdy !== 1'b1 && n < 60) begin
            @(negedge isa_clk);
            n++;
        end
        chk("chrdy_release", isa_chrdy, 1);
        @(negedge isa_clk);
        rd = isa_data_out; oe = isa_data_oe;
        isa_ior = 1'b1; isa_iow = 1'b1;
        repeat (4) @(negedge isa_clk);
    endtask

    // dly < 0: the crate never answers.
    task automatic do_op(input bit wr, input logic [9:0] a, input logic aen, input logic [7:0] d,
                         input int dly, input logic [CBW-1:0] din, input logic qv);
        bit hit, trig, ok, waited;
        int off, p0;
        logic [7:0] rd, exp_rd;
        logic oe;
        logic [CBW-1:0] exp_dout;
        hit  = !aen && a >= BASE && a <= BASE + B;
        off  = int'(a) - int'(BASE);
        trig = hit && ((wr && off == B - 1) || (!wr && off == 0));
        ok   = dly >= 0 && dly < TO;
        cb_data_in = din; cb_q = qv;
        ack_en = dly >= 0; ack_dly = (dly >= 0) ? dly : 0;
        p0 = req_pulses;
        exp_rd = 8'h00; exp_dout = '0;
        if (hit && wr && off < B) sh[off] = d;
        for (int i = 0; i < B; i++) exp_dout[8*i +: 8] = sh[i];
        if (hit && !wr && off == B) exp_rd = {4'b0, m_lam, m_to, m_q, 1'b0};
        isa_acc(wr, a, aen, d, rd, oe, waited);
        if (hit && wr && off == B) m_sub = d[3:0];
        if (trig) begin
            if (ok) begin
                m_q = qv; m_to = 0;
                if (!wr) for (int i = 0; i < B; i++) sh[i] = din[8*i +: 8];
            end else begin
                m_q = 0; m_to = 1;
                if (!wr) for (int i = 0; i < B; i++) sh[i] = 8'hFF;
            end
        end
        if (hit && !wr && off < B) exp_rd = sh[off];
        chk("data_oe", oe, hit && !wr);
        if (hit && !wr) chk("read_data", rd, exp_rd);
        chk("chrdy_stretch", waited, trig);
        chk("req_pulses", req_pulses - p0, trig);
        if (trig) begin
            chk("cb_write", seen_write, wr);
            if (wr) chk("cb_data_out", seen_dout, exp_dout);
            chk("req_width", req_w, ok ? dly + 1 : TO);
        end
        chk("cb_subaddr", cb_subaddr, m_sub);
        ack_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit wr, aen;
        isa_reset = 1'b1; isa_addr = 10'h000; isa_aen = 1'b0; isa_ior = 1'b1; isa_iow = 1'b1;
        isa_data_in = 8'h00; cb_data_in = '0; cb_q = 1'b0; m_lam = 1'b0;
`ifdef ISA_CAMAC_BRIDGE_IRQ_EN
        cb_lam = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge isa_clk);
        chk("rst_cb_req", cb_req, 0);
        chk("rst_chrdy", isa_chrdy, 1);
        chk("rst_oe", isa_data_oe, 0);
        chk("rst_data_out", isa_data_out, 0);
        chk("rst_cb_write", cb_write, 0);
        chk("rst_dout", cb_data_out, 0);
        isa_reset = 1'b0;
        repeat (2) @(negedge isa_clk);

        do_op(0, 10'h102, 0, 8'h00, 0, '0, 0);                  // status after reset
        do_op(1, 10'h100, 0, 8'h08, 0, '0, 0);
        do_op(1, 10'h101, 0, 8'h42, 3, '0, 1);                  // write cycle 0x4208
        chk("dout_4208", cb_data_out, 16'h4208);
        do_op(0, 10'h100, 0, 8'h00, 2, 16'hA55A, 1);             // read cycle
        do_op(0, 10'h101, 0, 8'h00, 2, 16'hA55A, 1);
        do_op(0, 10'h102, 0, 8'h00, 0, '0, 0);                  // status 0x02
        do_op(0, 10'h100, 0, 8'h00, -1, 16'h1234, 1);            // timeout
        do_op(0, 10'h102, 0, 8'h00, 0, '0, 0);                  // status 0x04
        do_op(0, 10'h100, 0, 8'h00, 7, 16'h3CC3, 0);             // last-cycle ack clears timeout
        do_op(0, 10'h102, 0, 8'h00, 0, '0, 0);
        do_op(0, 10'h0FF, 0, 8'h00, 0, '0, 0);                  // decode boundaries
        do_op(0, 10'h103, 0, 8'h00, 0, '0, 0);
        do_op(0, 10'h100, 1, 8'h00, 0, '0, 0);
        do_op(1, 10'h101, 1, 8'h77, 0, '0, 0);
        do_op(1, 10'h0FF, 0, 8'h77, 0, '0, 0);
        do_op(1, 10'h102, 0, 8'h85, 0, '0, 0);                  // subaddr 5

        // reset in the middle of a CAMAC read
        ack_en = 0; isa_addr = 10'h100; isa_aen = 1'b0;
        @(negedge isa_clk);
        isa_ior = 1'b0;
        repeat (6) @(negedge isa_clk);
        chk("busy_before_reset", cb_req, 1);
        isa_reset = 1'b1;
        #1;
        chk("rst_mid_cb_req", cb_req, 0);
        chk("rst_mid_chrdy", isa_chrdy, 1);
        isa_ior = 1'b1;
        repeat (3) @(negedge isa_clk);
        isa_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge isa_clk);
        do_op(0, 10'h102, 0, 8'h00, 0, '0, 0);

`ifdef ISA_CAMAC_BRIDGE_IRQ_EN
        do_op(1, 10'h102, 0, 8'h80, 0, '0, 0);
        cb_lam = 1'b1; m_lam = 1'b1;
        repeat (3) @(posedge isa_clk);
        #1;
        chk("irq_on", isa_irq, 1);
        do_op(0, 10'h102, 0, 8'h00, 0, '0, 0);                  // status bit3
        do_op(1, 10'h102, 0, 8'h00, 0, '0, 0);
        chk("irq_off", isa_irq, 0);
        cb_lam = 1'b0; m_lam = 1'b0;
        repeat (4) @(negedge isa_clk);
`endif

        for (int i = 0; i < 90; i++) begin
            wr  = $urandom_range(0, 1);
            aen = ($urandom_range(0, 7) == 0);
            do_op(wr, 10'(BASE - 2 + $urandom_range(0, 6)), aen, 8'($urandom),
                  int'($urandom_range(0, 10)) - 1, CBW'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
